dmem_port_arbiter: RTL and testbench

Sits between the pipeline's data-memory port and the single-port dmem. It sequences a post-reset program/data loading phase, during which an external loader owns dmem and the core is stalled. After loading it arbitrates dmem between the core and a debug/QED-checker requester. The core has priority; a starvation counter bounds how long the debug port can be locked out.

---
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: loader phase after reset, then core-priority sharing with a debug port.
// Latency: grant and dmem mux are combinational; debug read data returns one cycle after dbg_gnt.
// Backpressure: core_stall makes the core hold its access; debug holds dbg_req until dbg_gnt.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   reload            in RUN, request to return to the LOAD phase
//   loading, ld_*     external loader write port; owns dmem while loading = 1
//   core_*            pipeline data-memory port (priority requester)
//   dbg_*             debug / QED-checker port (starvation-bounded requester)
//   mem_*             single-port dmem; mem_rdata is valid one cycle after its address
module dmem_port_arbiter #(
    parameter int ADDR_LEN      = 32,
    parameter int DATA_LEN      = 32,
    parameter int MAX_WAIT      = 8,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reload,
    output logic                loading,

    input  logic                ld_valid,
    input  logic [ADDR_LEN-1:0] ld_addr,
    input  logic [DATA_LEN-1:0] ld_wdata,
    input  logic                ld_done,
    output logic                ld_ready,

    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_LEN-1:0] core_addr,
    input  logic [DATA_LEN-1:0] core_wdata,
    output logic                core_stall,
    output logic [DATA_LEN-1:0] core_rdata,

    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_LEN-1:0] dbg_addr,
    input  logic [DATA_LEN-1:0] dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_LEN-1:0] dbg_rdata,

    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t     RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_RUN;
    localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;   // consecutive RUN cycles the debug port was denied
    logic       dbg_rd_q, dbg_rd_d;       // previous cycle granted a debug read

    logic in_load;
    logic dbg_forced;
    logic core_win;
    logic dbg_win;

    // Arbitration decision for the current cycle.
    always_comb begin
        in_load    = (state_q == ST_LOAD);
        // Debug has waited long enough: it overrides the core for one access.
        dbg_forced = !in_load && dbg_req && (wait_cnt_q == MAX_WAIT_C);
        core_win   = !in_load && !dbg_forced && core_req;
        dbg_win    = !in_load && dbg_req && (dbg_forced || !core_req);
    end

    // Status outputs.
    assign loading    = in_load;
    assign ld_ready   = in_load;
    assign dbg_gnt    = dbg_win;
    assign core_stall = core_req && !core_win;   // also covers every core_req during LOAD
    assign core_rdata = mem_rdata;
    assign dbg_rdata  = mem_rdata;
    assign dbg_rvalid = dbg_rd_q;

    // dmem request mux. When idle in RUN the core address is still presented
    // (with mem_we low) so the core can read speculatively.
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = 1'b0;
        if (in_load) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_valid;
        end else if (dbg_win) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
        end else if (core_win) begin
            mem_we    = core_we;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dbg_rd_d   = dbg_win && !dbg_we;

        if (in_load) begin
            // A write presented together with ld_done still goes out this cycle.
            if (ld_done) begin
                state_d = ST_RUN;
            end
        end else if (reload) begin
            // The access granted this cycle completes; its read data still returns.
            state_d = ST_LOAD;
        end

        // The counter only measures denials in RUN; it restarts on any grant,
        // on a withdrawn request, and whenever LOAD is current or about to be.
        if (in_load || (state_d == ST_LOAD) || dbg_win || !dbg_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            wait_cnt_q <= '0;
            dbg_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dbg_rd_q   <= dbg_rd_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by randomized traffic.
// Latency: debug read data expected exactly one cycle after its grant.
// Backpressure: debug requests are held until granted; the core request is free-running.
module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int OWN_NONE = 0;
    localparam int OWN_CORE = 1;
    localparam int OWN_DBG  = 2;
    localparam int OWN_LD   = 3;

    logic        clk;
    logic        reset;
    logic        reload;
    logic        loading;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_done;
    logic        ld_ready;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    dmem_port_arbiter #(
        .ADDR_LEN(32), .DATA_LEN(32), .MAX_WAIT(MAX_WAIT), .LOAD_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .reload(reload), .loading(loading),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done), .ld_ready(ld_ready),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical single-port dmem, 16 words, registered read.
    logic [31:0] dmem [16];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[5:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: abstract memory contents, phase, denial count.
    logic [31:0] ref_mem [16];
    bit          m_load;
    int          m_denied;          // consecutive RUN cycles the pending debug request lost
    bit          core_rd_vld;
    logic [31:0] core_rd_exp;
    int          last_owner;
    bit          last_act_gnt;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        return a;
    endfunction

    // One clock cycle: inputs are already set (called at posedge+1).
    task automatic step();
        int          owner;
        bit          e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        #3;
        if (m_load)                                 owner = ld_valid ? OWN_LD : OWN_NONE;
        else if (dbg_req && m_denied >= MAX_WAIT)   owner = OWN_DBG;
        else if (core_req)                          owner = OWN_CORE;
        else if (dbg_req)                           owner = OWN_DBG;
        else                                        owner = OWN_NONE;

        e_addr  = m_load ? ld_addr  : (owner == OWN_DBG) ? dbg_addr  : core_addr;
        e_wdata = m_load ? ld_wdata : (owner == OWN_DBG) ? dbg_wdata : core_wdata;
        case (owner)
            OWN_LD:   e_we = 1'b1;
            OWN_CORE: e_we = core_we;
            OWN_DBG:  e_we = dbg_we;
            default:  e_we = 1'b0;
        endcase

        chk("loading",    32'(loading),    32'(m_load));
        chk("ld_ready",   32'(ld_ready),   32'(m_load));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(owner == OWN_DBG));
        chk("core_stall", 32'(core_stall), 32'(core_req && owner != OWN_CORE));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_addr",   mem_addr,        e_addr);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        if (core_rd_vld) chk("core_rdata", core_rdata, core_rd_exp);

        if (owner == OWN_DBG && !dbg_we)
            sb_q.push_back('{cyc: cyc + 1, data: ref_mem[dbg_addr[5:2]]});
        core_rd_vld = (owner == OWN_CORE) && !core_we;
        core_rd_exp = ref_mem[core_addr[5:2]];
        if (e_we) ref_mem[e_addr[5:2]] = e_wdata;

        last_owner   = owner;
        last_act_gnt = dbg_gnt;

        if (m_load) begin
            m_denied = 0;
            if (ld_done) m_load = 1'b0;
        end else begin
            if (dbg_req && owner != OWN_DBG) m_denied++;
            else                             m_denied = 0;
            if (reload) begin
                m_load   = 1'b1;
                m_denied = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pairs every dbg_rvalid with the oldest expected debug read.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dbg_rvalid_missing: no rvalid in cycle %0d, expected data %h", sb_q[0].cyc, sb_q[0].data);
                void'(sb_q.pop_front());
            end
            if (dbg_rvalid) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL dbg_rvalid_unexpected: rvalid=1 data %h, expected no read return (cycle %0d)", dbg_rdata, cyc);
                end else begin
                    rd_exp_t e;
                    e = sb_q.pop_front();
                    chk("dbg_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("dbg_rdata", dbg_rdata, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        reload = 0; ld_valid = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    initial begin
        int k;
        bit done;
        for (int i = 0; i < 16; i++) begin
            dmem[i]    = '0;
            ref_mem[i] = '0;
        end
        idle_inputs();
        core_req    = 1;
        reset       = 1;
        m_load      = 1;
        m_denied    = 0;
        core_rd_vld = 0;
        last_owner  = OWN_NONE;

        // Outputs while held in reset follow LOAD.
        #2;
        chk("rst_loading",    32'(loading),    32'd1);
        chk("rst_ld_ready",   32'(ld_ready),   32'd1);
        chk("rst_core_stall", 32'(core_stall), 32'd1);
        chk("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        core_req = 0;

        // Loader: two writes, second one with ld_done.
        ld_valid = 1; ld_addr = 4; ld_wdata = 32'hDEADBEEF; step();
        ld_addr = 8; ld_wdata = 32'h12345678; ld_done = 1; step();
        idle_inputs();
        chk("loaded_word8", dmem[2], 32'h12345678);

        // Uncontended debug read of addr 4.
        dbg_req = 1; dbg_addr = 4; step();
        dbg_req = 0; step();

        // Starvation bound: core hogs the port.
        core_req = 1; core_addr = 8;
        dbg_req = 1; dbg_addr = 8;
        k = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (last_act_gnt) done = 1; else k++;
        end
        chk("starve_len", 32'(k), 32'(MAX_WAIT));
        dbg_req = 0; step();

        // Core write wins over a fresh debug request.
        core_we = 1; core_addr = 12; core_wdata = 32'hA5;
        dbg_req = 1; dbg_addr = 0; step();
        chk("wait_cnt_inc", 32'(dut.wait_cnt_q), 32'd1);
        core_req = 0; core_we = 0; step();
        dbg_req = 0; core_req = 1; core_addr = 12; step();
        core_req = 0; step();
        chk("core_write_a5", dmem[3], 32'hA5);

        // reload during a granted debug read.
        dbg_req = 1; dbg_addr = 8; reload = 1; step();
        dbg_req = 0; reload = 0; core_req = 1; step();
        core_req = 0; ld_done = 1; step();
        ld_done = 0;

        // Async reset one cycle after a debug read grant.
        dbg_req = 1; dbg_addr = 4; step();
        dbg_req = 0; core_req = 1;
        chk("pre_rst_rvalid", 32'(dbg_rvalid), 32'd1);
        sb_q.delete();
        #1 reset = 1;
        #1;
        chk("mid_rst_rvalid",  32'(dbg_rvalid),      32'd0);
        chk("mid_rst_loading", 32'(loading),         32'd1);
        chk("mid_rst_wait",    32'(dut.wait_cnt_q),  32'd0);
        m_load = 1; m_denied = 0; core_rd_vld = 0; last_owner = OWN_NONE;
        @(posedge clk); #1;
        reset = 0;
        core_req = 0;
        ld_valid = 1; ld_addr = 16; ld_wdata = 32'h0BADF00D; ld_done = 1; step();
        idle_inputs();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_addr  = rand_addr();
            ld_wdata = $urandom;
            if (m_load) begin
                ld_done = ($urandom_range(0, 5) == 0);
                reload  = 1'($urandom_range(0, 1));
            end else begin
                ld_done = 1'($urandom_range(0, 1));
                reload  = ($urandom_range(0, 39) == 0);
            end
            core_req   = ($urandom_range(0, 99) < 70);
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = rand_addr();
            core_wdata = $urandom;
            if (!dbg_req || last_owner == OWN_DBG) begin
                dbg_req   = ($urandom_range(0, 2) == 0);
                dbg_we    = ($urandom_range(0, 3) == 0);
                dbg_addr  = rand_addr();
                dbg_wdata = $urandom;
            end
            step();
        end

        idle_inputs();
        step();
        step();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
